// File: rtl/entrada_valor_pkg.sv
// Shared types and widths for the IN-instruction input unit.
package pkg_entrada;

    // Width of the captured value; the immediate extender's valor input uses the same width.
    localparam int LARG_VALOR = 18;

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        ESPERA_SOLTO = 2'd1,
        ESPERA_PRESS = 2'd2,
        ENTREGA      = 2'd3
    } estado_entrada_t;

endpackage

// File: rtl/entrada_valor_filtro.sv
// Confirm-button conditioning: synchroniser, debounce filter and press-edge detect.
module filtro_botao #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao,
    output logic db,
    output logic evt_press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   r_db_prev;
    logic                   w_botao_s;

    assign w_botao_s = r_sync[SYNC_STAGES-1];

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], botao};
        end
    end

    // The filtered level only moves after DEBOUNCE_CYC consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_botao_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_db  <= w_botao_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Previous filtered level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_prev <= 1'b0;
        end else begin
            r_db_prev <= r_db;
        end
    end

    assign db        = r_db;
    assign evt_press = r_db & ~r_db_prev;

endmodule

// File: rtl/entrada_valor.sv
// IN-instruction input unit: stalls the datapath until the user confirms a switch value.
//
// state        | meaning
// OCIOSO       | no IN pending, stall follows req_in only
// ESPERA_SOLTO | IN pending, button still held from before; wait for release
// ESPERA_PRESS | IN pending, waiting for a fresh debounced press
// ENTREGA      | value captured, pronto strobe, stall released this cycle
module entrada_valor
    import pkg_entrada::*;
#(
    parameter int DATA_W       = LARG_VALOR,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] chaves,
    input  logic              botao,
    input  logic              req_in,
    output logic [DATA_W-1:0] valor,
    output logic              pronto,
    output logic              pausa,
    output logic              aguardando
);

    estado_entrada_t   r_estado;
    estado_entrada_t   w_prox;
    logic [DATA_W-1:0] r_chaves_sync [SYNC_STAGES];
    logic [DATA_W-1:0] r_valor;
    logic [DATA_W-1:0] w_chaves_s;
    logic              w_db;
    logic              w_evt_press;
    logic              w_captura;

    filtro_botao #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_filtro (
        .clk       (clk),
        .rst_n     (rst_n),
        .botao     (botao),
        .db        (w_db),
        .evt_press (w_evt_press)
    );

    assign w_chaves_s = r_chaves_sync[SYNC_STAGES-1];

    // Switch synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chaves_sync[i] <= '0;
            end
        end else begin
            r_chaves_sync[0] <= chaves;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chaves_sync[i] <= r_chaves_sync[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic; dropping req_in while waiting aborts without a capture.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (req_in) begin
                    w_prox = w_db ? ESPERA_SOLTO : ESPERA_PRESS;
                end
            end
            ESPERA_SOLTO: begin
                if (!req_in) begin
                    w_prox = OCIOSO;
                end else if (!w_db) begin
                    w_prox = ESPERA_PRESS;
                end
            end
            ESPERA_PRESS: begin
                if (!req_in) begin
                    w_prox = OCIOSO;
                end else if (w_evt_press) begin
                    w_prox = ENTREGA;
                end
            end
            ENTREGA: begin
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    // Output decode; the stall is gated by rst_n so it drops the moment reset asserts.
    always_comb begin
        w_captura  = (r_estado == ESPERA_PRESS) && req_in && w_evt_press;
        pronto     = (r_estado == ENTREGA);
        aguardando = (r_estado == ESPERA_SOLTO) || (r_estado == ESPERA_PRESS);
        pausa      = rst_n && req_in && (r_estado != ENTREGA);
    end

    // Captured value holds until the next capture or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valor <= '0;
        end else if (w_captura) begin
            r_valor <= w_chaves_s;
        end
    end

    assign valor = r_valor;

endmodule

// File: tb/tb_entrada_valor.sv
// Bench for entrada_valor with a short debounce window.
module tb_entrada_valor;
    import pkg_entrada::*;

    localparam int DW = LARG_VALOR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] chaves = '0;
    logic          botao = 1'b0;
    logic          req_in = 1'b0;
    logic [DW-1:0] valor;
    logic          pronto;
    logic          pausa;
    logic          aguardando;

    int            checks = 0;
    int            errors = 0;
    int            n_pronto = 0;
    logic [DW-1:0] sb_q[$];

    entrada_valor #(
        .DATA_W       (DW),
        .DEBOUNCE_CYC (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chaves     (chaves),
        .botao      (botao),
        .req_in     (req_in),
        .valor      (valor),
        .pronto     (pronto),
        .pausa      (pausa),
        .aguardando (aguardando)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pronto pops one expected value.
    always @(negedge clk) begin
        if (rst_n && pronto) begin
            n_pronto++;
            chk("pronto_pausa", 32'(pausa), 32'd0);
            if (sb_q.size() == 0) begin
                chk("pronto_unexpected", 32'd1, 32'd0);
            end else begin
                chk("valor_sb", 32'(valor), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pronto(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (pronto) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(tag, 32'd0, 32'd1);
    endtask

    int base;

    initial begin
        // Reset state
        #2;
        chk("rst_valor", 32'(valor), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_pausa", 32'(pausa), 32'd0);
        chk("rst_aguard", 32'(aguardando), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Basic IN
        chaves = 18'h2ABCD;
        req_in = 1'b1;
        #1;
        chk("basic_pausa_now", 32'(pausa), 32'd1);
        sb_q.push_back(18'h2ABCD);
        botao = 1'b1;
        base = n_pronto;
        wait_pronto("basic_timeout", 30);
        chk("basic_pausa_pronto", 32'(pausa), 32'd0);
        chaves = 18'h11111;
        req_in = 1'b0;
        step(1);
        chk("basic_idle_aguard", 32'(aguardando), 32'd0);
        chk("basic_idle_pronto", 32'(pronto), 32'd0);
        botao = 1'b0;
        step(10);
        chk("basic_count", 32'(n_pronto - base), 32'd1);
        chk("basic_valor_hold", 32'(valor), 32'h2ABCD);

        // Glitch rejection
        req_in = 1'b1;
        step(2);
        chk("glitch_aguard", 32'(aguardando), 32'd1);
        base = n_pronto;
        botao = 1'b1;
        step(3);
        botao = 1'b0;
        step(12);
        chk("glitch_no_pronto", 32'(n_pronto - base), 32'd0);
        chk("glitch_pausa", 32'(pausa), 32'd1);
        chaves = 18'h15555;
        sb_q.push_back(18'h15555);
        botao = 1'b1;
        wait_pronto("glitch_timeout", 30);
        req_in = 1'b0;
        step(8);
        botao = 1'b0;
        step(10);
        chk("glitch_count", 32'(n_pronto - base), 32'd1);

        // Held button before request
        botao = 1'b1;
        step(10);
        req_in = 1'b1;
        chaves = 18'h0F0F0;
        base = n_pronto;
        step(12);
        chk("held_no_pronto", 32'(n_pronto - base), 32'd0);
        chk("held_aguard", 32'(aguardando), 32'd1);
        botao = 1'b0;
        step(8);
        sb_q.push_back(18'h0F0F0);
        botao = 1'b1;
        wait_pronto("held_timeout", 30);
        req_in = 1'b0;
        step(2);
        botao = 1'b0;
        step(10);
        chk("held_count", 32'(n_pronto - base), 32'd1);

        // Back-to-back IN with req_in held high
        base = n_pronto;
        req_in = 1'b1;
        chaves = 18'h00001;
        sb_q.push_back(18'h00001);
        botao = 1'b1;
        wait_pronto("b2b_first_timeout", 30);
        chaves = 18'h3FFFF;
        step(15);
        chk("b2b_single_press", 32'(n_pronto - base), 32'd1);
        chk("b2b_waiting", 32'(aguardando), 32'd1);
        botao = 1'b0;
        step(8);
        sb_q.push_back(18'h3FFFF);
        botao = 1'b1;
        wait_pronto("b2b_second_timeout", 30);
        req_in = 1'b0;
        step(2);
        botao = 1'b0;
        step(10);
        chk("b2b_count", 32'(n_pronto - base), 32'd2);
        chk("b2b_valor", 32'(valor), 32'h3FFFF);

        // Abort while waiting
        base = n_pronto;
        req_in = 1'b1;
        chaves = 18'h12345;
        step(3);
        chk("abort_aguard", 32'(aguardando), 32'd1);
        req_in = 1'b0;
        step(1);
        chk("abort_idle", 32'(aguardando), 32'd0);
        botao = 1'b1;
        step(12);
        botao = 1'b0;
        step(10);
        chk("abort_no_pronto", 32'(n_pronto - base), 32'd0);
        chk("abort_valor", 32'(valor), 32'h3FFFF);

        // Asynchronous reset mid-wait
        req_in = 1'b1;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valor", 32'(valor), 32'd0);
        chk("arst_pausa", 32'(pausa), 32'd0);
        chk("arst_pronto", 32'(pronto), 32'd0);
        chk("arst_aguard", 32'(aguardando), 32'd0);
        req_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // Negative value and its sign extension
        req_in = 1'b1;
        chaves = 18'h20000;
        sb_q.push_back(18'h20000);
        botao = 1'b1;
        wait_pronto("neg_timeout", 30);
        chk("neg_valor", 32'(valor), 32'h20000);
        chk("neg_ext", {{(32-DW){valor[DW-1]}}, valor}, 32'hFFFE0000);
        req_in = 1'b0;
        step(2);
        botao = 1'b0;
        step(10);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
